// File: rtl/count_checker.sv
`default_nettype none
// ============================================================================
// count_checker : passive monitor predicting hold / +1 on an observed counter
// Revision      : 1.0
// ============================================================================
module count_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_data,
  input  logic             cnt_en,
  input  logic             pause,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [3:0] LOCK_TGT  = 4'(LOCK_COUNT);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [3:0]       match_cnt;
  logic [3:0]       match_cnt_nxt;
  logic [WIDTH-1:0] prev;
  logic             adv_q;
  logic [WIDTH-1:0] exp_val;
  logic             match;
  logic             locked_nxt;
  logic             err_nxt;
  logic             wrap_nxt;
  logic [ERR_W-1:0] err_base;
  logic [ERR_W-1:0] err_count_nxt;

  assign exp_val = adv_q ? prev + WIDTH'(1) : prev;
  assign match   = (cnt_data == exp_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      match_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    match_cnt_nxt = match_cnt;
    case (state)
      ST_IDLE: begin
        state_nxt     = ST_SEARCH;
        match_cnt_nxt = 4'd0;
      end
      ST_SEARCH: begin
        if (match) begin
          match_cnt_nxt = match_cnt + 4'd1;
          if (match_cnt + 4'd1 == LOCK_TGT) begin
            state_nxt = ST_LOCKED;
          end
        end else begin
          match_cnt_nxt = 4'd0;
        end
      end
      ST_LOCKED: begin
        if (!match) begin
          state_nxt     = ST_SEARCH;
          match_cnt_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        match_cnt_nxt = 4'd0;
      end
    endcase
  end

  // locked is qualified by the current match so it drops together with err_pulse
  always_comb begin
    locked_nxt    = (state == ST_LOCKED) && match;
    err_nxt       = (state == ST_LOCKED) && !match;
    wrap_nxt      = (state != ST_IDLE) && adv_q && (&prev) && (cnt_data == '0);
    err_base      = err_clr ? '0 : err_count;
    err_count_nxt = err_base;
    if (err_nxt && (err_base != '1)) begin
      err_count_nxt = err_base + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      adv_q      <= 1'b0;
      expected   <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
    end else begin
      prev       <= cnt_data;
      adv_q      <= cnt_en & ~pause;
      expected   <= exp_val;
      locked     <= locked_nxt;
      err_pulse  <= err_nxt;
      wrap_pulse <= wrap_nxt;
      err_count  <= err_count_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_count_checker.sv
`default_nettype none
// ============================================================================
// tb_count_checker : scoreboard bench for count_checker (directed + random)
// Revision         : 1.0
// ============================================================================
module tb_count_checker;

  localparam int WIDTH      = 8;
  localparam int LOCK_COUNT = 4;
  localparam int ERR_W      = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] cnt_data = '0;
  logic             cnt_en = 1'b0;
  logic             pause = 1'b0;
  logic             err_clr = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic             wrap_pulse;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] expected;

  always #5 clk = ~clk;

  count_checker #(
    .WIDTH      (WIDTH),
    .LOCK_COUNT (LOCK_COUNT),
    .ERR_W      (ERR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_data   (cnt_data),
    .cnt_en     (cnt_en),
    .pause      (pause),
    .err_clr    (err_clr),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .err_count  (err_count),
    .expected   (expected)
  );

  typedef struct packed {
    logic             lk;
    logic             ep;
    logic             wp;
    logic [ERR_W-1:0] ec;
    logic [WIDTH-1:0] ex;
  } resp_t;

  resp_t sb[$];
  int    vectors     = 0;
  int    miscompares = 0;

  // Reference: phase 0 = no sample yet, 1 = hunting, 2 = locked
  int m_phase = 0;
  int m_prev  = 0;
  int m_adv   = 0;
  int m_run   = 0;
  int m_errs  = 0;
  int v       = 0;

  task automatic step(input int d, input bit en, input bit pa, input bit clr, input bit r);
    resp_t e;
    int    pred;
    bit    ok;
    @(negedge clk);
    cnt_data = 8'(d);
    cnt_en   = en;
    pause    = pa;
    err_clr  = clr;
    rst      = r;
    e = '0;
    if (r) begin
      m_phase = 0; m_prev = 0; m_adv = 0; m_run = 0; m_errs = 0;
    end else begin
      pred = (m_prev + m_adv) % 256;
      ok   = (d == pred);
      e.ex = 8'(pred);
      if (m_phase != 0) e.wp = (m_adv == 1) && (m_prev == 255) && (d == 0);
      if (m_phase == 2) begin
        if (ok) e.lk = 1'b1;
        else begin
          e.ep = 1'b1; m_phase = 1; m_run = 0;
        end
      end else if (m_phase == 1) begin
        if (ok) begin
          m_run++;
          if (m_run == LOCK_COUNT) m_phase = 2;
        end else m_run = 0;
      end else begin
        m_phase = 1; m_run = 0;
      end
      if (clr) m_errs = 0;
      if (e.ep && (m_errs < (1 << ERR_W) - 1)) m_errs++;
      e.ec   = ERR_W'(m_errs);
      m_prev = d;
      m_adv  = (en && !pa) ? 1 : 0;
    end
    sb.push_back(e);
  endtask

  task automatic count(input int n);
    for (int i = 0; i < n; i++) begin
      step(v, 1'b1, 1'b0, 1'b0, 1'b0);
      v = (v + 1) % 256;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, wanted %0h", nm, $time, a, e);
    end
  endtask

  initial begin : monitor
    resp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        chk("locked",     32'(locked),     32'(e.lk));
        chk("err_pulse",  32'(err_pulse),  32'(e.ep));
        chk("wrap_pulse", 32'(wrap_pulse), 32'(e.wp));
        chk("err_count",  32'(err_count),  32'(e.ec));
        chk("expected",   32'(expected),   32'(e.ex));
      end
    end
  end

  initial begin : stimulus
    int d;
    bit en, pa, clr, r;

    // clean run from zero
    do_reset(2); v = 0; count(12);
    // wrap through 255 -> 0
    do_reset(1); v = 250; count(9);
    // hold under pause, then a change while paused
    do_reset(1); v = 3; count(8);
    repeat (3) step(11, 1'b1, 1'b1, 1'b0, 1'b0);
    step(12, 1'b1, 1'b1, 1'b0, 1'b0);
    v = 12; count(8);
    // skipped value
    do_reset(1); v = 16; count(6);
    v = 23; count(7);
    // saturation, then clear coinciding with an error
    do_reset(1); v = 0; count(6);
    repeat (5) begin
      v = (v + 1) % 256; count(6);
    end
    v = (v + 1) % 256;
    step(v, 1'b1, 1'b0, 1'b1, 1'b0);
    v = (v + 1) % 256; count(6);
    v = (v + 1) % 256; count(6);
    // reset while locked, restart at 100
    do_reset(1); v = 100; count(8);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(0, 7) != 0);
      pa  = ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 40) == 0);
      r   = ($urandom_range(0, 300) == 0);
      d   = v;
      if ($urandom_range(0, 19) == 0) d = (v + int'($urandom_range(1, 255))) % 256;
      else if ($urandom_range(0, 63) == 0) begin
        v = 252; d = v;
      end
      step(d, en, pa, clr, r);
      if (r) v = int'($urandom_range(0, 255));
      else   v = (v + ((en && !pa) ? 1 : 0)) % 256;
    end
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses left unchecked, wanted 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
